// File: rtl/ddr2_pkg.sv
// Shared sizing for the DDR2 capture ring buffer.
package ddr2_pkg;
    localparam int DDR2_DATA_W = 16;
    localparam int DDR2_DEPTH  = 8;
    localparam int DDR2_PTR_W  = 3;
endpackage

// File: rtl/ddr2_strobe_edge.sv
// Registers the DDR strobe and flags either transition as one capture event.
module ddr2_strobe_edge (
    input  logic clk,
    input  logic reset,
    input  logic strobe,
    output logic evt
);
    logic strobe_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) strobe_q <= 1'b0;
        else        strobe_q <= strobe;
    end

    assign evt = strobe ^ strobe_q;
endmodule

// File: rtl/ddr2_ring_buffer8.sv
// Eight-entry capture buffer: when armed, each DDR strobe edge stores din at the
// write pointer; the read side is a plain combinational mux on readPtr.
module ddr2_ring_buffer8
    import ddr2_pkg::*;
#(
    parameter int DATA_W = DDR2_DATA_W,
    parameter int DEPTH  = DDR2_DEPTH,
    parameter int PTR_W  = DDR2_PTR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              listen,
    input  logic              strobe,
    input  logic [DATA_W-1:0] din,
    input  logic [PTR_W-1:0]  readPtr,
    output logic [DATA_W-1:0] dout
);
    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [PTR_W-1:0]             wptr;
    logic                         armed;
    logic                         evt;
    logic                         wr_en;

    ddr2_strobe_edge u_edge (
        .clk    (clk),
        .reset  (reset),
        .strobe (strobe),
        .evt    (evt)
    );

    assign wr_en = evt & armed;

    // wptr survives listen so a second burst continues where the first stopped;
    // it wraps naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            regs  <= '0;
            wptr  <= '0;
            armed <= 1'b0;
        end else begin
            if (wr_en) begin
                regs[wptr] <= din;
                wptr       <= wptr + 1'b1;
            end
            if (listen)
                armed <= 1'b1;
            else if (wr_en && wptr == LAST)
                armed <= 1'b0;
        end
    end

    assign dout = regs[readPtr];
endmodule

// File: tb/tb_ddr2_ring_buffer8.sv
// Directed bench for ddr2_ring_buffer8: table-driven readbacks plus hand sequences.
module tb_ddr2_ring_buffer8;
    logic        clk = 1'b0;
    logic        reset;
    logic        listen;
    logic        strobe;
    logic [15:0] din;
    logic [2:0]  readPtr;
    logic [15:0] dout;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          phase;
        logic [2:0]  ptr;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    ddr2_ring_buffer8 dut (
        .clk     (clk),
        .reset   (reset),
        .listen  (listen),
        .strobe  (strobe),
        .din     (din),
        .readPtr (readPtr),
        .dout    (dout)
    );

    always #5 clk = ~clk;

    // Input sanity outside reset.
    logic strobe_prev = 1'b0;
    always @(posedge clk) begin
        if (reset === 1'b1) begin
            if ($isunknown({listen, strobe, readPtr})) begin
                errors++;
                $display("FAIL xcheck_ctrl: listen=%b strobe=%b readPtr=%b required known", listen, strobe, readPtr);
            end
            if (strobe !== strobe_prev && $isunknown(din)) begin
                errors++;
                $display("FAIL xcheck_din: din=%h required known at strobe event", din);
            end
        end
        strobe_prev = (reset === 1'b1) ? strobe : 1'b0;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        listen = 1'b1;
        tick();
        listen = 1'b0;
    endtask

    task automatic ev(input logic [15:0] d);
        din    = d;
        strobe = ~strobe;
        tick();
    endtask

    task automatic chk(input string name, input logic [2:0] p, input logic [15:0] exp);
        readPtr = p;
        @(negedge clk);
        checks++;
        if (dout !== exp) begin
            errors++;
            $display("FAIL %s: readPtr=%0d dout=%h required %h", name, p, dout, exp);
        end
    endtask

    task automatic run_phase(input int ph, input string name);
        foreach (vecs[i])
            if (vecs[i].phase == ph) chk(name, vecs[i].ptr, vecs[i].exp);
    endtask

    initial begin
        logic [15:0] seqb [8];
        seqb = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD,
                 16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

        // phase 0: 0000..7777, phase 1: half-overwritten, phase 2: all AAAA..DDDD
        vecs.push_back('{0, 3'd0, 16'h0000}); vecs.push_back('{0, 3'd1, 16'h1111});
        vecs.push_back('{0, 3'd2, 16'h2222}); vecs.push_back('{0, 3'd3, 16'h3333});
        vecs.push_back('{0, 3'd4, 16'h4444}); vecs.push_back('{0, 3'd5, 16'h5555});
        vecs.push_back('{0, 3'd6, 16'h6666}); vecs.push_back('{0, 3'd7, 16'h7777});
        vecs.push_back('{1, 3'd0, 16'hAAAA}); vecs.push_back('{1, 3'd1, 16'hBBBB});
        vecs.push_back('{1, 3'd2, 16'hCCCC}); vecs.push_back('{1, 3'd3, 16'hDDDD});
        vecs.push_back('{1, 3'd4, 16'h4444}); vecs.push_back('{1, 3'd5, 16'h5555});
        vecs.push_back('{1, 3'd6, 16'h6666}); vecs.push_back('{1, 3'd7, 16'h7777});
        vecs.push_back('{2, 3'd0, 16'hAAAA}); vecs.push_back('{2, 3'd1, 16'hBBBB});
        vecs.push_back('{2, 3'd2, 16'hCCCC}); vecs.push_back('{2, 3'd3, 16'hDDDD});
        vecs.push_back('{2, 3'd4, 16'hAAAA}); vecs.push_back('{2, 3'd5, 16'hBBBB});
        vecs.push_back('{2, 3'd6, 16'hCCCC}); vecs.push_back('{2, 3'd7, 16'hDDDD});

        reset = 1'b0; listen = 1'b0; strobe = 1'b0; din = '0; readPtr = '0;
        repeat (3) tick();
        for (int p = 0; p < 8; p++) chk("reset_dout", 3'(p), 16'h0000);
        reset = 1'b1;
        tick();

        // Full burst 0000..7777
        arm();
        for (int i = 0; i < 8; i++) ev(16'(16'h1111 * i));
        run_phase(0, "burst_full");

        // Half burst, then resume at R4
        arm();
        for (int i = 0; i < 4; i++) ev(seqb[i]);
        run_phase(1, "burst_half");
        arm();
        for (int i = 4; i < 8; i++) ev(seqb[i]);
        run_phase(2, "burst_resume");

        // Write visible on dout right after the edge, readPtr held at 0
        readPtr = 3'd0;
        @(negedge clk);
        arm();
        ev(16'h0000);
        checks++;
        if (dout !== 16'h0000) begin
            errors++;
            $display("FAIL write_through: dout=%h required 0000", dout);
        end
        for (int i = 1; i < 8; i++) ev(16'(16'h1111 * i));
        run_phase(0, "reload");

        // Not armed: events ignored
        for (int i = 0; i < 8; i++) ev(seqb[i]);
        run_phase(0, "unarmed_ignore");

        // listen in the R7-write clock keeps armed; next event wraps to R0
        arm();
        for (int i = 0; i < 7; i++) ev(16'(16'h0101 * (i + 1)));
        listen = 1'b1;
        ev(16'h0808);
        listen = 1'b0;
        ev(16'h0909);
        chk("listen_wins_r7", 3'd7, 16'h0808);
        chk("listen_wins_r0", 3'd0, 16'h0909);
        chk("listen_wins_r1", 3'd1, 16'h0202);

        // Partial burst then reset mid-burst
        arm();
        for (int i = 0; i < 3; i++) ev(16'hEEEE);
        readPtr = 3'd2;
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (dout !== 16'h0000) begin
            errors++;
            $display("FAIL async_reset: dout=%h required 0000", dout);
        end
        listen = 1'b1;
        for (int i = 0; i < 5; i++) begin
            strobe = ~strobe;
            din    = 16'h5A5A;
            tick();
        end
        listen = 1'b0;
        for (int p = 0; p < 8; p++) chk("reset_hold", 3'(p), 16'h0000);
        reset = 1'b1;
        tick();
        arm();
        ev(16'h1234);
        chk("post_reset_r0", 3'd0, 16'h1234);
        chk("post_reset_r1", 3'd1, 16'h0000);
        chk("post_reset_r3", 3'd3, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ddr2_ring_buffer8.md
DDR2_RING_BUFFER8 -- requirements
Module: ddr2_ring_buffer8

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, meaning number of storage entries; fixed power of two.
REQ-003 SHALL have parameter PTR_W, default 3, meaning pointer width, equal to log2(DEPTH).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port listen, input, 1 bit: level high for at least one clk arms capture.
REQ-007 SHALL have port strobe, input, 1 bit: DDR data strobe; every transition, rising or falling, is one capture event.
REQ-008 SHALL have port din, input, DATA_W bits: data word captured on each strobe event.
REQ-009 SHALL have port readPtr, input, PTR_W bits: selects the entry driven on dout.
REQ-010 SHALL have port dout, output, DATA_W bits: contents of entry R[readPtr].

Function
REQ-011 SHALL hold DEPTH registers R0..R7, each DATA_W bits wide.
REQ-012 SHALL register strobe every clk (strobe_q); a strobe event is strobe != strobe_q at a rising clk edge.
REQ-013 SHALL hold an armed flag: set on any clk with listen=1; cleared on the clk that writes R7.
REQ-014 SHALL, on a strobe event while armed, write din into R[wptr] on that clk edge, then increment wptr modulo 8.
REQ-015 SHALL ignore strobe events while not armed: no register write, no wptr change.
REQ-016 SHALL NOT let listen reset wptr; a later burst resumes at the current wptr, so 4 events write R0-R3, then listen plus 4 events write R4-R7.
REQ-017 SHALL wrap wptr from 7 to 0; a full 8-event burst ends with wptr=0 and armed=0.
REQ-018 SHALL let listen=1 in the same clk as the R7 write win: armed stays 1.
REQ-019 SHALL drive dout combinationally as R[readPtr], with no clock latency on a readPtr change.
REQ-020 SHALL make a write to the selected entry visible on dout immediately after the writing clk edge.
REQ-021 SHALL accept one strobe event per clk at most; strobe toggling faster than clk is out of specification.

Reset
REQ-022 SHALL, while reset=0, force R0..R7=0, wptr=0, armed=0 and strobe_q=0, asynchronously.
REQ-023 SHALL drive dout=0 for every readPtr value while reset is asserted.
REQ-024 SHALL ignore listen and strobe while reset is asserted; operation resumes on the first clk after release.
REQ-025 SHALL discard a partial burst interrupted by reset mid-burst; the next burst starts at R0.

Structure
REQ-026 SHALL take DATA_W=16, DEPTH=8 and PTR_W=3 from a shared package, ddr2_pkg.
REQ-027 SHALL place the strobe edge detector (strobe_q register, event output) in one sub-module, ddr2_strobe_edge; the remaining logic stays in ddr2_ring_buffer8.

Verification
REQ-028 SHALL cover: reset, listen 1 clk, 8 strobe events with din 0000,1111..7777 -> readPtr 0..7 returns 0000..7777.
REQ-029 SHALL cover: listen, 4 events AAAA,BBBB,CCCC,DDDD -> R0-R3 new, R4-R7 keep 4444..7777; then listen and 4 more events -> R4-R7 hold AAAA..DDDD.
REQ-030 SHALL cover: readPtr=0 holding AAAA, then listen and an 8-event burst starting with 0000 -> dout=0000 with readPtr unchanged.
REQ-031 SHALL cover: buffer loaded with non-zero data, reset held low 5 clks -> dout=0000 for all readPtr; after release, wptr=0.
REQ-032 SHALL cover: load 0000..7777, then 8 strobe events of AAAA..DDDD with no listen -> readPtr 0..7 still return 0000..7777.
REQ-033 SHALL check throughout, outside reset: listen, strobe and readPtr never X at a clk edge; din never X at a strobe event.
